// File: rtl/iscbdivn_pkg.sv
// Shared constants and helpers for the iscbdivn skewed-correlation stochastic divider.
package iscbdivn_pkg;

    // Fibonacci taps, bit k set for term x^(k+1): x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1
    localparam logic [15:0] TAP_W8  = 16'h00B8;
    localparam logic [15:0] TAP_W16 = 16'hB400;

    // Relation between the two incoming bits of one channel
    typedef enum logic [1:0] {
        PAIR_SAME   = 2'd0,
        PAIR_A_ONLY = 2'd1,
        PAIR_B_ONLY = 2'd2
    } pair_e;

    function automatic bit lfsr_w_legal(input int w);
        return (w == 8) || (w == 16);
    endfunction

    function automatic logic [15:0] lfsr_tap(input int w);
        return (w == 16) ? TAP_W16 : TAP_W8;
    endfunction

    function automatic pair_e classify(input logic a, input logic b);
        if (a == b) return PAIR_SAME;
        return a ? PAIR_A_ONLY : PAIR_B_ONLY;
    endfunction

endpackage

// File: rtl/iscbdivn_sync.sv
// One channel of the skewed synchronizer: delays unmatched dividend ones until a
// divisor one arrives, so that the registered pair is maximally correlated.
module skewed_sync_ch
    import iscbdivn_pkg::*;
#(
    parameter int SYNC_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic i_a,
    input  logic i_b,
    output logic o_sa,
    output logic o_sb,
    output logic o_sat
);

    localparam int CW = $clog2(SYNC_DEPTH + 1);
    localparam logic [CW-1:0] C_MAX = CW'(SYNC_DEPTH);

    logic [CW-1:0] r_cnt;
    logic          r_sa;
    logic          r_sb;
    logic          r_sat;

    logic [CW-1:0] w_cnt_n;
    logic          w_sa_n;
    logic          w_sb_n;
    logic          w_sat_n;
    pair_e         w_pair;

    assign w_pair = classify(i_a, i_b);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_sa_n  = i_a;
        w_sb_n  = i_b;
        w_cnt_n = r_cnt;
        w_sat_n = 1'b0;
        case (w_pair)
            PAIR_A_ONLY: begin
                if (r_cnt != C_MAX) begin
                    w_sa_n  = 1'b0;
                    w_cnt_n = r_cnt + 1'b1;
                end else begin
                    w_sat_n = 1'b1;
                end
            end
            PAIR_B_ONLY: begin
                if (r_cnt != '0) begin
                    w_sa_n  = 1'b1;
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_sat <= 1'b0;
        end else if (en) begin
            r_cnt <= w_cnt_n;
            r_sa  <= w_sa_n;
            r_sb  <= w_sb_n;
            r_sat <= w_sat_n;
        end
    end

    assign o_sa  = r_sa;
    assign o_sb  = r_sb;
    assign o_sat = r_sat;

endmodule

// File: rtl/iscbdivn.sv
// Multi-channel stochastic bitstream divider: skewed synchronizer, then a quotient
// history that is resampled through a shared LFSR whenever the divisor bit is 0.
module iscbdivn
    import iscbdivn_pkg::*;
#(
    parameter int                NCH        = 1,
    parameter int                SYNC_DEPTH = 4,
    parameter int                HIST_DEPTH = 4,
    parameter int                LFSR_W     = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 'h5A
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [NCH-1:0] dividend,
    input  logic [NCH-1:0] divisor,
    output logic [NCH-1:0] quot,
    output logic [NCH-1:0] sync_sat
);

    localparam int                IDX_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam logic [LFSR_W-1:0] TAP   = LFSR_W'(lfsr_tap(LFSR_W));

    if (!lfsr_w_legal(LFSR_W)) begin : g_bad_lfsr_w
        $error("iscbdivn: LFSR_W must be 8 or 16");
    end

    logic [LFSR_W-1:0] r_lfsr;
    logic [IDX_W-1:0]  w_idx;

    // Index is taken from the value before this edge's shift
    assign w_idx = (HIST_DEPTH > 1) ? r_lfsr[IDX_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (en) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAP)};
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic                  w_sa;
        logic                  w_sb;
        logic                  w_sat;
        logic [HIST_DEPTH-1:0] r_hist;
        logic                  r_quot;

        skewed_sync_ch #(
            .SYNC_DEPTH(SYNC_DEPTH)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .i_a  (dividend[i]),
            .i_b  (divisor[i]),
            .o_sa (w_sa),
            .o_sb (w_sb),
            .o_sat(w_sat)
        );

        // NOTE: the history is a handful of flops that must read zero after reset,
        // so it is reset like any other register rather than left as uninitialised RAM.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_hist <= '0;
                r_quot <= 1'b0;
            end else if (en) begin
                if (w_sb) begin
                    r_quot <= w_sa;
                    for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                        r_hist[k] <= r_hist[k-1];
                    end
                    r_hist[0] <= w_sa;
                end else begin
                    r_quot <= r_hist[w_idx];
                end
            end
        end

        assign quot[i]     = r_quot;
        assign sync_sat[i] = w_sat;
    end

endmodule

// File: tb/tb_iscbdivn.sv
// Directed self-checking bench for iscbdivn: a two-channel depth-4 instance and a
// single-channel depth-1 instance share clock, reset and enable.
module tb_iscbdivn;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] dividend;
    logic [1:0] divisor;
    logic [1:0] quot;
    logic [1:0] sync_sat;
    logic       h1_a;
    logic       h1_b;
    logic       h1_quot;
    logic       h1_sat;

    logic [7:0] m_lfsr;
    logic [1:0] a_log [16];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ones0;
    int         ones1;

    always #5 clk = ~clk;

    iscbdivn #(
        .NCH(2), .SYNC_DEPTH(4), .HIST_DEPTH(4), .LFSR_W(8), .LFSR_SEED(8'h5A)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .dividend(dividend), .divisor(divisor),
        .quot(quot), .sync_sat(sync_sat)
    );

    iscbdivn #(
        .NCH(1), .SYNC_DEPTH(4), .HIST_DEPTH(1), .LFSR_W(8), .LFSR_SEED(8'h5A)
    ) dut_h1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .dividend(h1_a), .divisor(h1_b),
        .quot(h1_quot), .sync_sat(h1_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge; the LFSR reference is x^8+x^6+x^5+x^4+1 in Fibonacci form
    task automatic step();
        @(posedge clk);
        if (!rst_n)  m_lfsr = 8'h5A;
        else if (en) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        dividend = 2'b00;
        divisor  = 2'b00;
        h1_a     = 1'b0;
        h1_b     = 1'b0;
        m_lfsr   = 8'h00;
        step();
        step();

        check("rst_quot", quot, 2'b00);
        check("rst_sat", sync_sat, 2'b00);
        check("rst_lfsr", dut.r_lfsr, 8'h5A);
        check("rst_cnt0", dut.g_ch[0].u_sync.r_cnt, 0);
        check("rst_h1_quot", h1_quot, 1'b0);

        // Divisor constant 1: quotient is the dividend two edges late, counter idle
        h1_a    = 1'b1;
        h1_b    = 1'b1;
        divisor = 2'b11;
        rst_n   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            dividend = {~k[0], k[0]};
            a_log[k] = dividend;
            step();
            check("h1_quot", h1_quot, (k >= 1) ? 1 : 0);
            check("alt_quot", quot, (k >= 1) ? a_log[k-1] : 2'b00);
            check("alt_cnt0", dut.g_ch[0].u_sync.r_cnt, 0);
            check("alt_cnt1", dut.g_ch[1].u_sync.r_cnt, 0);
        end

        // Saturation walk on channel 0, channel 1 idle
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        dividend = 2'b01;
        divisor  = 2'b00;
        for (int k = 0; k < 5; k++) begin
            step();
            check("sat_up_sa", dut.g_ch[0].u_sync.r_sa, (k == 4) ? 1 : 0);
            check("sat_up_sb", dut.g_ch[0].u_sync.r_sb, 0);
            check("sat_up_flag", sync_sat, (k == 4) ? 2'b01 : 2'b00);
            check("sat_up_cnt", dut.g_ch[0].u_sync.r_cnt, (k < 4) ? k + 1 : 4);
        end
        dividend = 2'b00;
        divisor  = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step();
            check("sat_dn_sa", dut.g_ch[0].u_sync.r_sa, 1);
            check("sat_dn_sb", dut.g_ch[0].u_sync.r_sb, 1);
            check("sat_dn_flag", sync_sat, 2'b00);
            check("sat_dn_cnt", dut.g_ch[0].u_sync.r_cnt, 3 - k);
            check("sat_dn_quot", quot, (k >= 1) ? 2'b01 : 2'b00);
        end
        check("sat_hist0", dut.g_ch[0].r_hist, 4'b0111);
        check("sat_hist1", dut.g_ch[1].r_hist, 4'b0000);

        // Freeze: inputs that would change every register are ignored
        en       = 1'b0;
        dividend = 2'b11;
        divisor  = 2'b00;
        repeat (10) step();
        check("frz_quot", quot, 2'b01);
        check("frz_sat", sync_sat, 2'b00);
        check("frz_cnt0", dut.g_ch[0].u_sync.r_cnt, 0);
        check("frz_hist0", dut.g_ch[0].r_hist, 4'b0111);
        check("frz_lfsr", dut.r_lfsr, m_lfsr);

        // Reset wins over a deasserted enable
        rst_n = 1'b0;
        step();
        check("frst_quot", quot, 2'b00);
        check("frst_sat", sync_sat, 2'b00);
        check("frst_cnt0", dut.g_ch[0].u_sync.r_cnt, 0);
        check("frst_hist0", dut.g_ch[0].r_hist, 4'b0000);
        check("frst_lfsr", dut.r_lfsr, 8'h5A);

        // All-zero inputs never populate the history
        rst_n    = 1'b1;
        en       = 1'b1;
        dividend = 2'b00;
        divisor  = 2'b00;
        for (int k = 0; k < 8; k++) begin
            step();
            check("zero_quot", quot, 2'b00);
        end
        check("zero_hist0", dut.g_ch[0].r_hist, 4'b0000);
        check("zero_hist1", dut.g_ch[1].r_hist, 4'b0000);
        check("zero_lfsr", dut.r_lfsr, m_lfsr);

        // Statistical run: 0.25 / 0.5 should average to 0.5 on each channel
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ones0 = 0;
        ones1 = 0;
        for (int k = 0; k < 4098; k++) begin
            for (int c = 0; c < 2; c++) begin
                dividend[c] = ($urandom_range(0, 3) == 0);
                divisor[c]  = ($urandom_range(0, 1) == 1);
            end
            step();
            if (k >= 2) begin
                ones0 += int'(quot[0]);
                ones1 += int'(quot[1]);
            end
        end
        $display("stat ones ch0=%0d ch1=%0d of 4096", ones0, ones1);
        check("mean_ch0", (ones0 >= 1843 && ones0 <= 2253) ? 1 : 0, 1);
        check("mean_ch1", (ones1 >= 1843 && ones1 <= 2253) ? 1 : 0, 1);
        check("stat_lfsr", dut.r_lfsr, m_lfsr);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iscbdivn.md
ISCBDIVN -- requirements
Module: iscbdivn

Interface
REQ-001 SHALL provide parameter NCH, default 1: number of independent divider channels, 1..32.
REQ-002 SHALL provide parameter SYNC_DEPTH, default 4: skewed-synchronizer counter capacity, 1..15.
REQ-003 SHALL provide parameter HIST_DEPTH, default 4: quotient history buffer entries per channel, power of two, 1..16.
REQ-004 SHALL provide parameter LFSR_W, default 8: index-LFSR width, 8 or 16 only.
REQ-005 SHALL provide parameter LFSR_SEED, default 8'h5A (zero-extended to LFSR_W): nonzero LFSR reset value.
REQ-006 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL provide port rst_n  input  1  synchronous active-low reset.
REQ-008 SHALL provide port en  input  1  clock enable; 0 freezes all state.
REQ-009 SHALL provide port dividend  input  NCH  dividend bitstreams, one bit per channel.
REQ-010 SHALL provide port divisor  input  NCH  divisor bitstreams, one bit per channel; dividend <= divisor in value.
REQ-011 SHALL provide port quot  output  NCH  quotient bitstreams, registered.
REQ-012 SHALL provide port sync_sat  output  NCH  registered flag: synchronizer saturated and passed an uncorrelated dividend 1.

Function
REQ-013 SHALL keep per channel a sync counter c in 0..SYNC_DEPTH; sync outputs (a',b') from inputs (a,b):
- a=b: a'=a, b'=b, c unchanged.
- a=1,b=0, c<SYNC_DEPTH: a'=0, b'=0, c+1.
- a=1,b=0, c=SYNC_DEPTH: a'=1, b'=0, c unchanged, sync_sat=1.
- a=0,b=1, c>0: a'=1, b'=1, c-1.
- a=0,b=1, c=0: a'=0, b'=1, c unchanged.
REQ-014 SHALL register (a',b') into stage-1 regs sa, sb, plus sync_sat, on every enabled edge; sync_sat=0 in all cases other than the saturation case.
REQ-015 SHALL, on each enabled edge, with sb=1: quot <= sa and shift sa into history (hist[0] <= sa, hist[k] <= hist[k-1]).
REQ-016 SHALL, on each enabled edge, with sb=0: quot <= hist[idx], history unchanged; idx = LFSR[log2(HIST_DEPTH)-1:0]; HIST_DEPTH=1 gives idx=0.
REQ-017 SHALL share one Fibonacci LFSR across channels: lfsr <= {lfsr[W-2:0], ^(lfsr & TAP)}, advanced every enabled edge; idx uses the pre-shift value.
REQ-018 SHALL give latency of 2 enabled edges from input sample to quot; sync_sat latency 1 enabled edge.
REQ-019 SHALL hold all registers, including the LFSR, when en=0; quot and sync_sat hold their last values.
REQ-020 SHALL operate channels independently; only the LFSR is shared.

Reset
REQ-021 SHALL, on a clock edge with rst_n=0 (regardless of en): c=0, sa=sb=0, hist all 0, quot=0, sync_sat=0, lfsr=LFSR_SEED.
REQ-022 SHALL treat reset mid-stream identically; the first enabled edge after release samples fresh inputs, with no carry-over of counter or history.

Structure
REQ-023 SHALL place TAP constants (8: x^8+x^6+x^5+x^4+1; 16: x^16+x^14+x^13+x^11+1) and the LFSR_W legality check in package iscbdivn_pkg.
REQ-024 SHALL implement the per-channel synchronizer (REQ-013/014) as sub-module skewed_sync_ch, instantiated NCH times via generate.
REQ-025 SHALL be implementable in 120-400 lines of RTL with no latches and no combinational path from input to output.

Verification
REQ-026 SHALL test: HIST_DEPTH=1, dividend=divisor=1 constant -> quot=1 from the 2nd enabled edge after reset release onward.
REQ-027 SHALL test: divisor=1 constant, dividend=0,1,0,1... -> quot equals dividend delayed 2 cycles, c stays 0.
REQ-028 SHALL test: SYNC_DEPTH=4, a=1,b=0 for 5 cycles -> sa=0 for 4 cycles (c 0->4), 5th cycle sa=1 with sync_sat=1; then a=0,b=1 for 4 cycles -> sa=sb=1 each cycle, c back to 0.
REQ-029 SHALL test: NCH=2, HIST_DEPTH=4, independent Bernoulli dividend p=0.25, divisor p=0.5, 4096 cycles -> each quot mean 0.50 +/-0.05.
REQ-030 SHALL test: en=0 for 10 cycles mid-stream -> quot, sync_sat, c, hist, lfsr unchanged; then rst_n=0 for 1 edge -> all zero, lfsr=8'h5A.
REQ-031 SHALL test: divisor=0 constant from reset, dividend=0 -> quot=0 throughout, history stays 0.
